// File: rtl/pipe_op_issuer.sv
// Operand issuer for the two-stage AND/XOR pipeline: buffers operand
// pairs, issues them on credit, captures results and returns them in order.
//
// Ports: clk, rst (sync, active-high); s_valid/s_ready/s_a/s_b upstream;
// op_in1/op_in2/op_control/op_out to and from the pipeline;
// m_valid/m_ready/m_data downstream; err sticky mismatch flag.
// Optional: define OPISSUE_CHECK_EN to build the result reference check.
module pipe_op_issuer #(
  parameter int W      = 32,
  parameter int IDEPTH = 4,
  parameter int RDEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_a,
  input  logic [W-1:0] s_b,
  output logic [W-1:0] op_in1,
  output logic [W-1:0] op_in2,
  output logic         op_control,
  input  logic [W-1:0] op_out,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         err
);

  localparam int IAW = $clog2(IDEPTH);
  localparam int RAW = $clog2(RDEPTH);

  localparam logic [IAW:0]   IFULL = (IAW+1)'(IDEPTH);
  localparam logic [IAW:0]   ICNT1 = 1;
  localparam logic [IAW-1:0] IPTR1 = 1;
  localparam logic [RAW:0]   RCNT1 = 1;
  localparam logic [RAW-1:0] RPTR1 = 1;
  localparam logic [RAW+1:0] RLIM  = (RAW+2)'(RDEPTH);

  logic [W-1:0] ia_q [IDEPTH];
  logic [W-1:0] ib_q [IDEPTH];
  logic [W-1:0] rd_q [RDEPTH];

  logic [IAW-1:0] in_wp_q, in_wp_d;
  logic [IAW-1:0] in_rp_q, in_rp_d;
  logic [IAW:0]   in_cnt_q, in_cnt_d;
  logic [RAW-1:0] r_wp_q, r_wp_d;
  logic [RAW-1:0] r_rp_q, r_rp_d;
  logic [RAW:0]   r_cnt_q, r_cnt_d;
  logic           ctl_q, ctl_d;
  logic           cap_q, cap_d;
  logic           rdy_en_q, rdy_en_d;

  logic           in_empty;
  logic           in_full;
  logic           r_empty;
  logic           s_push;
  logic           fire;
  logic           r_push;
  logic           r_pop;
  logic [W-1:0]   head_a;
  logic [W-1:0]   head_b;
  logic [RAW+1:0] credit;

  assign in_empty = (in_cnt_q == '0);
  assign in_full  = (in_cnt_q == IFULL);
  assign r_empty  = (r_cnt_q == '0);

  // rdy_en_q keeps s_ready low through reset and
  // releases it one cycle after rst falls.
  assign s_ready = rdy_en_q & ~in_full;
  assign s_push  = s_valid & s_ready;

  assign head_a = ia_q[in_rp_q];
  assign head_b = ib_q[in_rp_q];
  assign op_in1 = in_empty ? '0 : head_a;
  assign op_in2 = in_empty ? '0 : head_b;

  // Every issued op will land in the result FIFO, so count the
  // ops still in the pipeline against its free space.
  assign credit = {1'b0, r_cnt_q}
                + {{(RAW+1){1'b0}}, ctl_q}
                + {{(RAW+1){1'b0}}, cap_q};
  assign fire   = ~in_empty & (credit < RLIM);

  assign op_control = ctl_q;

  // op_out is only meaningful in the cycle after stage 2 loads.
  assign r_push  = cap_q;
  assign m_valid = ~r_empty;
  assign r_pop   = m_valid & m_ready;
  assign m_data  = r_empty ? '0 : rd_q[r_rp_q];

  always_comb begin
    in_wp_d  = in_wp_q;
    in_rp_d  = in_rp_q;
    in_cnt_d = in_cnt_q;
    r_wp_d   = r_wp_q;
    r_rp_d   = r_rp_q;
    r_cnt_d  = r_cnt_q;
    ctl_d    = fire;
    cap_d    = ctl_q;
    rdy_en_d = 1'b1;
    if (s_push) in_wp_d = in_wp_q + IPTR1;
    if (fire)   in_rp_d = in_rp_q + IPTR1;
    unique case ({s_push, fire})
      2'b10:   in_cnt_d = in_cnt_q + ICNT1;
      2'b01:   in_cnt_d = in_cnt_q - ICNT1;
      default: in_cnt_d = in_cnt_q;
    endcase
    if (r_push) r_wp_d = r_wp_q + RPTR1;
    if (r_pop)  r_rp_d = r_rp_q + RPTR1;
    unique case ({r_push, r_pop})
      2'b10:   r_cnt_d = r_cnt_q + RCNT1;
      2'b01:   r_cnt_d = r_cnt_q - RCNT1;
      default: r_cnt_d = r_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_wp_q  <= '0;
      in_rp_q  <= '0;
      in_cnt_q <= '0;
      r_wp_q   <= '0;
      r_rp_q   <= '0;
      r_cnt_q  <= '0;
      ctl_q    <= 1'b0;
      cap_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      in_wp_q  <= in_wp_d;
      in_rp_q  <= in_rp_d;
      in_cnt_q <= in_cnt_d;
      r_wp_q   <= r_wp_d;
      r_rp_q   <= r_rp_d;
      r_cnt_q  <= r_cnt_d;
      ctl_q    <= ctl_d;
      cap_q    <= cap_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  // Storage arrays need no reset; the counts gate every read.
  always_ff @(posedge clk) begin
    if (s_push) begin
      ia_q[in_wp_q] <= s_a;
      ib_q[in_wp_q] <= s_b;
    end
    if (r_push) rd_q[r_wp_q] <= op_out;
  end

`ifdef OPISSUE_CHECK_EN
  localparam logic [W-1:0] ONE_W = 1;

  logic [W-1:0] chk1_q, chk1_d;
  logic [W-1:0] chk2_q, chk2_d;
  logic         err_q, err_d;

  // Two-entry reference queue shadowing ctl_q/cap_q.
  always_comb begin
    chk1_d = chk1_q;
    chk2_d = chk2_q;
    if (fire)  chk1_d = (head_a & head_b) ^ ONE_W;
    if (ctl_q) chk2_d = chk1_q;
    err_d = err_q | (cap_q & (op_out != chk2_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk1_q <= '0;
      chk2_q <= '0;
      err_q  <= 1'b0;
    end else begin
      chk1_q <= chk1_d;
      chk2_q <= chk2_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_op_issuer.sv
// Directed bench for pipe_op_issuer with a behavioural
// model of the two-stage AND/XOR pipeline.
module tb_pipe_op_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic [31:0] op_in1;
  logic [31:0] op_in2;
  logic        op_control;
  logic [31:0] op_out;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic        flip = 1'b0;
  logic [31:0] p1a, p1b, p2a, p2b;

  always #5 clk = ~clk;

  pipe_op_issuer #(.W(32), .IDEPTH(4), .RDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b),
    .op_in1(op_in1), .op_in2(op_in2),
    .op_control(op_control), .op_out(op_out),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .err(err)
  );

  always @(posedge clk) begin
    if (rst) begin
      p1a <= '0; p1b <= '0; p2a <= '0; p2b <= '0;
    end else begin
      p1a <= op_in1;
      p1b <= op_in2;
      if (op_control) begin
        p2a <= p1a;
        p2b <= p1b;
      end
    end
  end

  assign op_out = ((p2a & p2b) ^ 32'd1) ^ {31'd0, flip};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    tick; tick;
    checks++;
    if (op_in1 !== 32'd0) begin
      failures++; $display("FAIL reset_op_in1 got=%h exp=0", op_in1);
    end
    checks++;
    if (op_in2 !== 32'd0) begin
      failures++; $display("FAIL reset_op_in2 got=%h exp=0", op_in2);
    end
    checks++;
    if (op_control !== 1'b0) begin
      failures++; $display("FAIL reset_ctl got=%b exp=0", op_control);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      failures++; $display("FAIL reset_mvalid got=%b exp=0", m_valid);
    end
    checks++;
    if (m_data !== 32'd0) begin
      failures++; $display("FAIL reset_mdata got=%h exp=0", m_data);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b exp=0", err);
    end
    checks++;
    if (s_ready !== 1'b0) begin
      failures++; $display("FAIL reset_sready_in got=%b exp=0", s_ready);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++; $display("FAIL reset_sready_after got=%b exp=1", s_ready);
    end
  endtask

  task automatic test_single;
    logic [5:1] ctl_v, mv_v;
    logic [31:0] md;
    md = '0;
    m_ready = 1'b1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++; $display("FAIL single_sready got=%b exp=1", s_ready);
    end
    s_valid = 1'b1; s_a = 32'hFFFF0000; s_b = 32'h0F0F0F0F;
    tick;
    s_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      ctl_v[k] = op_control;
      mv_v[k] = m_valid;
      if (k == 4) md = m_data;
      tick;
    end
    checks++;
    if (ctl_v !== 5'b00010) begin
      failures++; $display("FAIL single_ctl got=%b exp=00010", ctl_v);
    end
    checks++;
    if (mv_v !== 5'b01000) begin
      failures++; $display("FAIL single_mvalid got=%b exp=01000", mv_v);
    end
    checks++;
    if (md !== 32'h0F0F0001) begin
      failures++; $display("FAIL single_data got=%h exp=0f0f0001", md);
    end
  endtask

  task automatic test_streaming;
    int rcv, first, last, nordy;
    rcv = 0; first = -1; last = -1; nordy = 0;
    m_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      if (m_valid) begin
        checks++;
        if (m_data !== (32'(rcv) ^ 32'd1)) begin
          failures++;
          $display("FAIL stream_data idx=%0d got=%h exp=%h",
                   rcv, m_data, 32'(rcv) ^ 32'd1);
        end
        if (first < 0) first = n;
        last = n;
        rcv++;
      end
      if (n < 8) begin
        s_valid = 1'b1; s_a = 32'(n); s_b = 32'hFFFFFFFF;
        if (!s_ready) nordy++;
      end else begin
        s_valid = 1'b0;
      end
      tick;
    end
    checks++;
    if (nordy != 0) begin
      failures++; $display("FAIL stream_sready low_cycles=%0d exp=0", nordy);
    end
    checks++;
    if (rcv != 8) begin
      failures++; $display("FAIL stream_count got=%0d exp=8", rcv);
    end
    checks++;
    if (last - first != 7) begin
      failures++; $display("FAIL stream_gaps span=%0d exp=7", last - first);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL stream_err got=%b exp=0", err);
    end
  endtask

  task automatic test_backpressure;
    int j, nctl, rcv;
    j = 0; nctl = 0; rcv = 0;
    m_ready = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (op_control) nctl++;
      s_valid = (j < 10); s_a = 32'hA0 + 32'(j); s_b = 32'hFF;
      if (s_valid && s_ready) j++;
      tick;
    end
    checks++;
    if (j != 8) begin
      failures++; $display("FAIL bp_accepted got=%0d exp=8", j);
    end
    checks++;
    if (s_ready !== 1'b0) begin
      failures++; $display("FAIL bp_sready got=%b exp=0", s_ready);
    end
    checks++;
    if (nctl != 4) begin
      failures++; $display("FAIL bp_issued got=%0d exp=4", nctl);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hA1) begin
      failures++;
      $display("FAIL bp_head got=%b/%h exp=1/000000a1", m_valid, m_data);
    end
    m_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (m_valid) begin
        checks++;
        if (m_data !== ((32'hA0 + 32'(rcv)) ^ 32'd1)) begin
          failures++;
          $display("FAIL bp_data idx=%0d got=%h exp=%h", rcv, m_data,
                   (32'hA0 + 32'(rcv)) ^ 32'd1);
        end
        rcv++;
      end
      s_valid = (j < 10); s_a = 32'hA0 + 32'(j); s_b = 32'hFF;
      if (s_valid && s_ready) j++;
      tick;
    end
    s_valid = 1'b0;
    checks++;
    if (rcv != 10) begin
      failures++; $display("FAIL bp_drained got=%0d exp=10", rcv);
    end
    checks++;
    if (j != 10) begin
      failures++; $display("FAIL bp_accepted_all got=%0d exp=10", j);
    end
  endtask

  task automatic test_reset_mid;
    int nmv, waitc;
    logic [5:1] mv_v;
    logic [31:0] md;
    nmv = 0; waitc = 0; md = '0;
    m_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      s_valid = 1'b1; s_a = 32'h10 + 32'(n); s_b = 32'hFF;
      tick;
    end
    s_valid = 1'b0;
    while (!op_control && waitc < 6) begin
      tick;
      waitc++;
    end
    checks++;
    if (op_control !== 1'b1) begin
      failures++; $display("FAIL mid_ctl_timeout got=%b exp=1", op_control);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (m_valid) nmv++;
      tick;
    end
    checks++;
    if (nmv != 0) begin
      failures++; $display("FAIL mid_stale_mvalid got=%0d exp=0", nmv);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      failures++; $display("FAIL mid_sready got=%b exp=1", s_ready);
    end
    s_valid = 1'b1; s_a = 32'h12345678; s_b = 32'hF0F0F0F0;
    tick;
    s_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      mv_v[k] = m_valid;
      if (k == 4) md = m_data;
      tick;
    end
    checks++;
    if (mv_v !== 5'b01000) begin
      failures++; $display("FAIL mid_latency got=%b exp=01000", mv_v);
    end
    checks++;
    if (md !== 32'h10305071) begin
      failures++; $display("FAIL mid_data got=%h exp=10305071", md);
    end
  endtask

`ifdef OPISSUE_CHECK_EN
  task automatic test_check;
    int ncap, n2, bad_pre, bad_post;
    logic prev_ctl;
    ncap = 0; n2 = -1; bad_pre = 0; bad_post = 0; prev_ctl = 1'b0;
    m_ready = 1'b1;
    for (int n = 0; n < 14; n++) begin
      if (n2 >= 0 && n > n2) begin
        if (err !== 1'b1) bad_post++;
      end else if (err !== 1'b0) begin
        bad_pre++;
      end
      if (prev_ctl) ncap++;
      flip = prev_ctl && (ncap == 2);
      if (flip) n2 = n;
      prev_ctl = op_control;
      s_valid = (n < 3); s_a = 32'h30 + 32'(n); s_b = 32'hFF;
      tick;
    end
    flip = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (n2 < 0) begin
      failures++; $display("FAIL chk_capture_missing got=%0d exp>=0", n2);
    end
    checks++;
    if (bad_pre != 0) begin
      failures++; $display("FAIL chk_err_early got=%0d exp=0", bad_pre);
    end
    checks++;
    if (bad_post != 0) begin
      failures++; $display("FAIL chk_err_sticky got=%0d exp=0", bad_post);
    end
    rst = 1'b1;
    tick;
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL chk_err_reset got=%b exp=0", err);
    end
    rst = 1'b0;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_streaming;
    test_backpressure;
    test_reset_mid;
`ifdef OPISSUE_CHECK_EN
    test_check;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
